fetch_stage: RTL

//  IF stage of the 5-stage pipeline. Owns the PC and drives a synchronous (1-cycle-latency) instruction BRAM.
//  Its IF/ID output register feeds inst/pc to the ID stage, where the decode controller consumes if_id_inst.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if_id_reg.sv | 61 ++++++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage_pkg                                              |
// | Description : Shared fetch-path constants. The bubble encoding and the     |
// |               default reset PC are also used by the ID/EX flush logic.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_stage_pkg;

  // addi x0,x0,0 : decodes to a harmless write of x0 with no memory access
  localparam logic [31:0] c_INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] c_PC_STEP          = 32'd4;

  // Redirect targets are forced onto a word boundary; misalignment is only
  // flagged, never trapped, by the fetch stage.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage_if_id_reg                                        |
// | Description : IF/ID pipeline register. Priority: flush > hold > load.     |
// |               A load of an invalid fetch stores the NOP bubble.            |
// | Ports       : clk, rst        clock, async active-high reset               |
// |               flush_i         clear to bubble (redirect)                   |
// |               hold_i          keep all fields (stall)                      |
// |               pc_i/pc4_i/inst_i/valid_i   values to load                   |
// |               pc_o/pc4_o/inst_o/valid_o   registered IF/ID fields          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] inst_i,
  input  logic        valid_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] inst_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      inst_q  <= c_INST_NOP;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      inst_q  <= c_INST_NOP;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      // BRAM output is meaningless before the first address was latched
      inst_q  <= valid_i ? inst_i : c_INST_NOP;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage                                                  |
// | Description : IF stage. Owns the PC, drives a 1-cycle-latency instruction  |
// |               BRAM and the IF/ID register; handles stalls and redirects.   |
// | Ports       : clk, rst            clock, async active-high reset           |
// |               stall               hold PC and IF/ID                        |
// |               redirect/_pc        taken branch/jump target from EX         |
// |               imem_addr           BRAM word address (from next PC)         |
// |               imem_rdata          BRAM data for the current PC             |
// |               if_id_pc/pc4/inst/valid   IF/ID outputs to decode            |
// |               misalign_err        sticky misaligned-redirect flag          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = c_RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_pc4,
  output logic [31:0]            if_id_inst,
  output logic                   if_id_valid,
  output logic                   misalign_err
);

  logic [31:0] pc_q;
  logic [31:0] next_pc_d;
  logic [31:0] pc_plus4;
  logic        fetch_valid_q;
  logic        misalign_q;

  assign pc_plus4 = pc_q + c_PC_STEP;

  // While fetch_valid_q is low the BRAM has not yet been given RESET_PC, so
  // the PC must not advance on the first edge.
  always_comb begin
    next_pc_d = pc_plus4;
    if (redirect) begin
      next_pc_d = align_word(redirect_pc);
    end else if (stall || !fetch_valid_q) begin
      next_pc_d = pc_q;
    end
  end

  // BRAM latches the address on the same edge the PC takes next_pc_d, so its
  // read data always belongs to pc_q.
  assign imem_addr = next_pc_d[IMEM_ADDR_W+1:2];

  logic unused_next_pc_bits;
  assign unused_next_pc_bits = ^{next_pc_d[31:IMEM_ADDR_W+2], next_pc_d[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= next_pc_d;
      fetch_valid_q <= 1'b1;
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign misalign_err = misalign_q;

  // Redirect flushes the wrong-path fetch currently at pc_q; the older
  // wrong-path instruction already in ID is squashed downstream.
  fetch_stage_if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .hold_i  (stall),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .inst_i  (imem_rdata),
    .valid_i (fetch_valid_q),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4),
    .inst_o  (if_id_inst),
    .valid_o (if_id_valid)
  );

endmodule
`default_nettype wire
